// File: rtl/rob_commit_if.sv
// ROB head / regfile / LSB / flush bundle seen by the commit sequencer.
// The master modport is the commit controller; slave is the ROB/regfile/LSB side.
interface rob_commit_if #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned CNT_W     = 32
);
    logic                 rdy;
    logic                 head_valid;
    logic                 head_ready;
    logic [ROB_IDX_W-1:0] head_idx;
    logic [1:0]           head_type;
    logic [4:0]           head_rd;
    logic [31:0]          head_val;
    logic                 head_mispredict;
    logic [31:0]          head_target;
    logic                 pop;
    logic                 write;
    logic [ROB_IDX_W-1:0] write_idx;
    logic [4:0]           write_rd;
    logic [31:0]          new_val;
    logic                 st_commit;
    logic [ROB_IDX_W-1:0] st_idx;
    logic                 st_done;
    logic                 jp_wrong;
    logic [31:0]          jp_pc;
    logic [CNT_W-1:0]     commit_cnt;

    modport master (
        input  rdy, head_valid, head_ready, head_idx, head_type, head_rd, head_val,
               head_mispredict, head_target, st_done,
        output pop, write, write_idx, write_rd, new_val, st_commit, st_idx,
               jp_wrong, jp_pc, commit_cnt
    );

    modport slave (
        output rdy, head_valid, head_ready, head_idx, head_type, head_rd, head_val,
               head_mispredict, head_target, st_done,
        input  pop, write, write_idx, write_rd, new_val, st_commit, st_idx,
               jp_wrong, jp_pc, commit_cnt
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer: retires the ROB head into the regfile, hands stores to the
// LSB with a request/done handshake, raises a one-cycle flush on mispredict, counts retires.
module rob_commit_ctrl #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned CNT_W     = 32
) (
    input logic          clk,
    input logic          rst,
    rob_commit_if.master bus
);
    typedef enum logic [1:0] {StRun = 2'd0, StStWait = 2'd1, StFlush = 2'd2} state_e;

    localparam logic [1:0] TypeReg    = 2'b00;
    localparam logic [1:0] TypeStore  = 2'b01;
    localparam logic [1:0] TypeBranch = 2'b10;

    state_e               state_q;
    logic                 write_q;
    logic [ROB_IDX_W-1:0] write_idx_q;
    logic [4:0]           write_rd_q;
    logic [31:0]          new_val_q;
    logic                 st_commit_q;
    logic [ROB_IDX_W-1:0] st_idx_q;
    logic                 jp_wrong_q;
    logic [31:0]          jp_pc_q;
    logic [CNT_W-1:0]     cnt_q;

    logic go;
    logic pop;

    assign go = bus.rdy & (state_q == StRun) & bus.head_valid & bus.head_ready;

    // Stores are popped only once the LSB reports completion.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            StRun:    pop = go & (bus.head_type != TypeStore);
            StStWait: pop = bus.rdy & bus.st_done;
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            write_q     <= 1'b0;
            write_idx_q <= '0;
            write_rd_q  <= '0;
            new_val_q   <= '0;
            st_commit_q <= 1'b0;
            st_idx_q    <= '0;
            jp_wrong_q  <= 1'b0;
            jp_pc_q     <= '0;
            cnt_q       <= '0;
        end else if (bus.rdy) begin
            write_q    <= 1'b0;
            jp_wrong_q <= 1'b0;
            if (pop) cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                StRun: begin
                    if (go) begin
                        case (bus.head_type)
                            TypeReg, TypeBranch: begin
                                write_q     <= (bus.head_rd != 5'd0);
                                write_idx_q <= bus.head_idx;
                                write_rd_q  <= bus.head_rd;
                                new_val_q   <= bus.head_val;
                                if ((bus.head_type == TypeBranch) && bus.head_mispredict) begin
                                    jp_wrong_q <= 1'b1;
                                    jp_pc_q    <= bus.head_target;
                                    state_q    <= StFlush;
                                end
                            end
                            TypeStore: begin
                                st_commit_q <= 1'b1;
                                st_idx_q    <= bus.head_idx;
                                state_q     <= StStWait;
                            end
                            default: ;
                        endcase
                    end
                end
                StStWait: begin
                    if (bus.st_done) begin
                        st_commit_q <= 1'b0;
                        state_q     <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.pop        = pop;
    assign bus.write      = write_q;
    assign bus.write_idx  = write_idx_q;
    assign bus.write_rd   = write_rd_q;
    assign bus.new_val    = new_val_q;
    assign bus.st_commit  = st_commit_q;
    assign bus.st_idx     = st_idx_q;
    assign bus.jp_wrong   = jp_wrong_q;
    assign bus.jp_pc      = jp_pc_q;
    assign bus.commit_cnt = cnt_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: a per-cycle vector table plus a reset-in-ST_WAIT sequence.
module tb_rob_commit_ctrl;
    logic clk;
    logic rst;

    rob_commit_if #(.ROB_IDX_W(4), .CNT_W(32)) bus ();

    rob_commit_ctrl #(.ROB_IDX_W(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        hv;
        logic        hr;
        logic [3:0]  idx;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        mis;
        logic [31:0] tgt;
        logic        sd;
    } in_t;

    typedef struct {
        logic        pop;
        logic        wr;
        logic [3:0]  widx;
        logic [4:0]  wrd;
        logic [31:0] nval;
        logic        stc;
        logic [3:0]  stidx;
        logic        jw;
        logic [31:0] jpc;
        logic [31:0] cnt;
    } exp_t;

    in_t  vin[$];
    exp_t vexp[$];
    int   checks;
    int   errors;

    task automatic add(input in_t a, input exp_t e);
        vin.push_back(a);
        vexp.push_back(e);
    endtask

    task automatic drive(input in_t v);
        bus.rdy             = v.rdy;
        bus.head_valid      = v.hv;
        bus.head_ready      = v.hr;
        bus.head_idx        = v.idx;
        bus.head_type       = v.ty;
        bus.head_rd         = v.rd;
        bus.head_val        = v.val;
        bus.head_mispredict = v.mis;
        bus.head_target     = v.tgt;
        bus.st_done         = v.sd;
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL step%0d %s got %h want %h", step, name, act, want);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive('{1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0});

        // in: rdy hv hr idx ty rd val mis tgt sd
        // exp: pop wr widx wrd nval stc stidx jw jpc cnt (registered values from prior edges)
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 5'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 32'd0});
        add('{1'b1, 1'b1, 1'b1, 4'd0, 2'd0, 5'd1, 32'h11, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b0, 4'd0, 5'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 32'd0});
        add('{1'b1, 1'b1, 1'b1, 4'd1, 2'd0, 5'd2, 32'h22, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b1, 4'd0, 5'd1, 32'h11, 1'b0, 4'd0, 1'b0, 32'h0, 32'd1});
        add('{1'b1, 1'b1, 1'b1, 4'd2, 2'd0, 5'd3, 32'h33, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b1, 4'd1, 5'd2, 32'h22, 1'b0, 4'd0, 1'b0, 32'h0, 32'd2});
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b1, 4'd2, 5'd3, 32'h33, 1'b0, 4'd0, 1'b0, 32'h0, 32'd3});
        // rd=0 commits but never writes
        add('{1'b1, 1'b1, 1'b1, 4'd3, 2'd0, 5'd0, 32'hDEAD, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b0, 4'd2, 5'd3, 32'h33, 1'b0, 4'd0, 1'b0, 32'h0, 32'd3});
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b0, 4'd3, 5'd0, 32'hDEAD, 1'b0, 4'd0, 1'b0, 32'h0, 32'd4});
        // store idx 5, st_done low for 4 cycles in ST_WAIT
        add('{1'b1, 1'b1, 1'b1, 4'd5, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b0, 4'd3, 5'd0, 32'hDEAD, 1'b0, 4'd0, 1'b0, 32'h0, 32'd4});
        for (int k = 0; k < 4; k++)
            add('{1'b1, 1'b1, 1'b1, 4'd5, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
                '{1'b0, 1'b0, 4'd3, 5'd0, 32'hDEAD, 1'b1, 4'd5, 1'b0, 32'h0, 32'd4});
        add('{1'b1, 1'b1, 1'b1, 4'd5, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1},
            '{1'b1, 1'b0, 4'd3, 5'd0, 32'hDEAD, 1'b1, 4'd5, 1'b0, 32'h0, 32'd4});
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b0, 4'd3, 5'd0, 32'hDEAD, 1'b0, 4'd5, 1'b0, 32'h0, 32'd5});
        // mispredicted branch, then a valid head that must not pop during FLUSH
        add('{1'b1, 1'b1, 1'b1, 4'd6, 2'd2, 5'd1, 32'h1004, 1'b1, 32'h2000, 1'b0},
            '{1'b1, 1'b0, 4'd3, 5'd0, 32'hDEAD, 1'b0, 4'd5, 1'b0, 32'h0, 32'd5});
        add('{1'b1, 1'b1, 1'b1, 4'd7, 2'd0, 5'd4, 32'h44, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b1, 4'd6, 5'd1, 32'h1004, 1'b0, 4'd5, 1'b1, 32'h2000, 32'd6});
        add('{1'b1, 1'b1, 1'b1, 4'd7, 2'd0, 5'd4, 32'h44, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b0, 4'd6, 5'd1, 32'h1004, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd6});
        // rdy low for 3 cycles right after a REG pop
        for (int k = 0; k < 3; k++)
            add('{1'b0, 1'b1, 1'b1, 4'd8, 2'd0, 5'd5, 32'h55, 1'b0, 32'h0, 1'b0},
                '{1'b0, 1'b1, 4'd7, 5'd4, 32'h44, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd7});
        add('{1'b1, 1'b1, 1'b1, 4'd8, 2'd0, 5'd5, 32'h55, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b1, 4'd7, 5'd4, 32'h44, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd7});
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b1, 4'd8, 5'd5, 32'h55, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd8});
        // st_done in RUN is ignored
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1},
            '{1'b0, 1'b0, 4'd8, 5'd5, 32'h55, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd8});
        add('{1'b1, 1'b1, 1'b1, 4'd9, 2'd3, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b1, 1'b0, 4'd8, 5'd5, 32'h55, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd8});
        // correctly predicted branch with rd=0
        add('{1'b1, 1'b1, 1'b1, 4'd10, 2'd2, 5'd0, 32'h77, 1'b0, 32'h3000, 1'b0},
            '{1'b1, 1'b0, 4'd8, 5'd5, 32'h55, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd9});
        add('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b0, 4'd10, 5'd0, 32'h77, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd10});
        // head valid but result not ready
        add('{1'b1, 1'b1, 1'b0, 4'd11, 2'd0, 5'd6, 32'h66, 1'b0, 32'h0, 1'b0},
            '{1'b0, 1'b0, 4'd10, 5'd0, 32'h77, 1'b0, 4'd5, 1'b0, 32'h2000, 32'd10});

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vin.size(); i++) begin
            @(negedge clk);
            drive(vin[i]);
            #1;
            chk("pop", i, 32'(bus.pop), 32'(vexp[i].pop));
            chk("write", i, 32'(bus.write), 32'(vexp[i].wr));
            chk("write_idx", i, 32'(bus.write_idx), 32'(vexp[i].widx));
            chk("write_rd", i, 32'(bus.write_rd), 32'(vexp[i].wrd));
            chk("new_val", i, bus.new_val, vexp[i].nval);
            chk("st_commit", i, 32'(bus.st_commit), 32'(vexp[i].stc));
            chk("st_idx", i, 32'(bus.st_idx), 32'(vexp[i].stidx));
            chk("jp_wrong", i, 32'(bus.jp_wrong), 32'(vexp[i].jw));
            chk("jp_pc", i, bus.jp_pc, vexp[i].jpc);
            chk("commit_cnt", i, bus.commit_cnt, vexp[i].cnt);
        end

        // Reset in the middle of ST_WAIT, with a rdy-low hold first.
        @(negedge clk);
        drive('{1'b1, 1'b1, 1'b1, 4'd12, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0});
        #1 chk("rs_pop_store", 100, 32'(bus.pop), 32'd0);
        @(negedge clk);
        drive('{1'b0, 1'b1, 1'b1, 4'd12, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1});
        #1;
        chk("rs_st_commit", 101, 32'(bus.st_commit), 32'd1);
        chk("rs_st_idx", 101, 32'(bus.st_idx), 32'd12);
        chk("rs_pop_rdy_low", 101, 32'(bus.pop), 32'd0);
        @(negedge clk);
        #1;
        chk("rs_st_commit_hold", 102, 32'(bus.st_commit), 32'd1);
        chk("rs_cnt_hold", 102, bus.commit_cnt, 32'd10);
        rst = 1'b1;
        drive('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        drive('{1'b1, 1'b1, 1'b1, 4'd1, 2'd0, 5'd1, 32'h5, 1'b0, 32'h0, 1'b0});
        #1;
        chk("rs_st_commit_clr", 103, 32'(bus.st_commit), 32'd0);
        chk("rs_st_idx_clr", 103, 32'(bus.st_idx), 32'd0);
        chk("rs_cnt_clr", 103, bus.commit_cnt, 32'd0);
        chk("rs_run_pop", 103, 32'(bus.pop), 32'd1);
        @(negedge clk);
        drive('{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0});
        #1;
        chk("rs_write", 104, 32'(bus.write), 32'd1);
        chk("rs_new_val", 104, bus.new_val, 32'h5);
        chk("rs_cnt_one", 104, bus.commit_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
